// File: rtl/calendar_set_ctrl.sv
// Clock/calendar register bank with 1 Hz Gregorian timekeeping and a
// push-button set mode that walks and edits year..sec one field at a time.
module calendar_set_ctrl #(
    parameter logic [13:0] RESET_YEAR = 14'd2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        run,
    input  logic        but_1,
    input  logic        but_2,
    input  logic        but_3,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [13:0] year,
    output logic        leap,
    output logic [2:0]  edit_field,
    output logic        blink
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_YEAR  = 3'd1,
        ST_MONTH = 3'd2,
        ST_DAY   = 3'd3,
        ST_HOUR  = 3'd4,
        ST_MIN   = 3'd5,
        ST_SEC   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  sec_q, sec_d, min_q, min_d;
    logic [4:0]  hour_q, hour_d, day_q, day_d;
    logic [3:0]  month_q, month_d;
    logic [13:0] year_q, year_d;
    logic        blink_q, blink_d;
    logic        prevBut1_q, prevBut2_q, prevBut3_q;

    logic riseBut1, riseBut2, riseBut3;
    logic incEn, decEn, countEn;
    logic [4:0] dimCur, dimNew;

    function automatic logic isLeap(input logic [13:0] y);
        return (y[1:0] == 2'b00) &&
               (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
    endfunction

    function automatic logic [4:0] daysInMonth(input logic [3:0] m, input logic lp);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return lp ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    // Prev registers reset high so a button held through reset never fires.
    assign riseBut1 = but_1 & ~prevBut1_q;
    assign riseBut2 = but_2 & ~prevBut2_q;
    assign riseBut3 = but_3 & ~prevBut3_q;
    assign incEn    = riseBut2 & ~riseBut3;
    assign decEn    = riseBut3 & ~riseBut2;
    assign countEn  = (state_q == ST_RUN) && tick_1hz && run;
    assign dimCur   = daysInMonth(month_q, leap);

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        blink_d = blink_q;

        if (countEn) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    if (hour_q == 5'd23) begin
                        hour_d = 5'd0;
                        if (day_q >= dimCur) begin
                            day_d = 5'd1;
                            if (month_q == 4'd12) begin
                                month_d = 4'd1;
                                year_d  = (year_q == 14'd9999) ? 14'd0 : year_q + 14'd1;
                            end else begin
                                month_d = month_q + 4'd1;
                            end
                        end else begin
                            day_d = day_q + 5'd1;
                        end
                    end else begin
                        hour_d = hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        // A mode press wins over any simultaneous field edit.
        if (riseBut1) begin
            blink_d = 1'b1;
            case (state_q)
                ST_RUN:   state_d = ST_YEAR;
                ST_YEAR:  state_d = ST_MONTH;
                ST_MONTH: state_d = ST_DAY;
                ST_DAY:   state_d = ST_HOUR;
                ST_HOUR:  state_d = ST_MIN;
                ST_MIN:   state_d = ST_SEC;
                default:  state_d = ST_RUN;
            endcase
        end else if (state_q != ST_RUN) begin
            if (tick_1hz) begin
                blink_d = ~blink_q;
            end
            case (state_q)
                ST_YEAR: begin
                    if (incEn) year_d = (year_q == 14'd9999) ? 14'd0 : year_q + 14'd1;
                    if (decEn) year_d = (year_q == 14'd0) ? 14'd9999 : year_q - 14'd1;
                end
                ST_MONTH: begin
                    if (incEn) month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
                    if (decEn) month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
                end
                ST_DAY: begin
                    if (incEn) day_d = (day_q >= dimCur) ? 5'd1 : day_q + 5'd1;
                    if (decEn) day_d = (day_q <= 5'd1) ? dimCur : day_q - 5'd1;
                end
                ST_HOUR: begin
                    if (incEn) hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
                    if (decEn) hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
                end
                ST_MIN: begin
                    if (incEn) min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
                    if (decEn) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                end
                ST_SEC: begin
                    if (incEn) sec_d = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
                    if (decEn) sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
                end
                default: ;
            endcase
        end

        // Month/year edits can shrink the month; keep day legal in the same cycle.
        dimNew = daysInMonth(month_d, isLeap(year_d));
        if (day_d > dimNew) begin
            day_d = dimNew;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hour_q     <= 5'd0;
            day_q      <= 5'd1;
            month_q    <= 4'd1;
            year_q     <= RESET_YEAR;
            blink_q    <= 1'b1;
            prevBut1_q <= 1'b1;
            prevBut2_q <= 1'b1;
            prevBut3_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            day_q      <= day_d;
            month_q    <= month_d;
            year_q     <= year_d;
            blink_q    <= blink_d;
            prevBut1_q <= but_1;
            prevBut2_q <= but_2;
            prevBut3_q <= but_3;
        end
    end

    assign sec        = sec_q;
    assign min        = min_q;
    assign hour       = hour_q;
    assign day        = day_q;
    assign month      = month_q;
    assign year       = year_q;
    assign leap       = isLeap(year_q);
    assign edit_field = state_q;
    assign blink      = blink_q;

endmodule
